seq_comparator: RTL and testbench
=================================

SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst; all state changes only on the rising edge of clk.
REQ-002 SHALL take parameter WIDTH, default 16: operand width in bits.
REQ-003 SHALL take parameter CHUNK, default 4: bits compared per cycle; NCHUNK = WIDTH/CHUNK.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port start_valid  in  1  request to compare.
REQ-007 SHALL have port start_ready  out  1  block can accept a request.
REQ-008 SHALL have port a  in  WIDTH  operand A.
REQ-009 SHALL have port b  in  WIDTH  operand B.
REQ-010 SHALL have port signed_mode  in  1  1 = two's-complement compare; 0 = unsigned compare.
REQ-011 SHALL have port res_valid  out  1  result available.
REQ-012 SHALL have port res_ready  in  1  consumer accepts result.
REQ-013 SHALL have ports a_gt_b, a_eq_b, a_lt_b  out  1 each  registered result flags.
REQ-014 SHALL have port busy  out  1  high in CMP and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, CMP, DONE.
REQ-016 IDLE: SHALL drive start_ready=1; on start_valid=1, SHALL:
- capture a, b and signed_mode;
- clear all flags;
- set chunk index to NCHUNK-1;
- go to CMP.
REQ-017 CMP: SHALL compare one CHUNK-bit slice per cycle, MSB chunk first.
REQ-018 Signed mode: SHALL invert bit WIDTH-1 of both captured operands before comparing.
REQ-019 At the first differing chunk, SHALL latch gt/lt; later chunks SHALL NOT change the latched decision.
REQ-020 SHALL go CMP to DONE after chunk 0 is processed; SHALL set a_eq_b=1 if no chunk differed.
REQ-021 DONE: SHALL drive res_valid=1 and hold all flags stable until res_ready=1, then go to IDLE.
REQ-022 Flags SHALL be one-hot whenever res_valid=1.
REQ-023 SHALL hold the last result's flags in IDLE until the next acceptance.
REQ-024 Latency (baseline): res_valid SHALL rise exactly NCHUNK cycles after the accepting edge, independent of data.
REQ-025 start_ready SHALL be 0 in CMP and DONE; start_valid there SHALL be ignored.
REQ-026 There SHALL be no same-cycle DONE to accept path; minimum request spacing is NCHUNK+2 cycles.
REQ-027 CHUNK==WIDTH SHALL give a single-cycle CMP.
REQ-028 WIDTH%CHUNK!=0 or CHUNK<1 SHALL fail elaboration.

Reset
REQ-029 When rst=1, the block SHALL go to state IDLE.
REQ-030 When rst=1, the block SHALL drive start_ready=1, res_valid=0, busy=0 and a_gt_b=a_eq_b=a_lt_b=0.
REQ-031 Reset asserted mid-CMP or in DONE SHALL discard the operation with no result delivered.
REQ-032 Reset SHALL take priority over start_valid and res_ready in the same cycle.

Configuration
REQ-033 SHALL support macro SEQ_COMPARATOR_EARLY_EXIT_EN.
REQ-034 With the macro defined: CMP SHALL go to DONE on the cycle the first differing chunk is found; res_valid SHALL rise p cycles after acceptance, where p = 1-based position of that chunk from the MSB.
REQ-035 With the macro defined: equal operands SHALL still take NCHUNK cycles.
REQ-036 Without the macro: fixed latency per REQ-024.
REQ-037 Results SHALL be identical with and without the macro.

Structure
REQ-038 Package cmp_pkg SHALL hold the FSM state enum (IDLE, CMP, DONE) and the 3-bit result encoding constants (GT, EQ, LT).
REQ-039 The design SHALL contain one combinational sub-module, cmp_chunk: parametrised CHUNK-bit unsigned gt/eq/lt slice, instantiated once on the muxed slice.

Verification
REQ-040 The bench SHALL use WIDTH=16, CHUNK=4 and cover these scenarios:
- a=0x1234, b=0x1234, unsigned -> a_eq_b=1; res_valid 4 cycles after acceptance, with and without the macro.
- a=0x8000, b=0x0001 -> unsigned: a_gt_b=1; signed: a_lt_b=1.
- a=0xA000, b=0x5000, unsigned -> a_gt_b=1; res_valid after 1 cycle with the macro, 4 cycles without.
- a=0x0003, b=0x0004 -> a_lt_b=1 after 4 cycles in both builds.
- DONE with res_ready=0 for 5 cycles and start_valid=1 throughout -> flags and res_valid stable, start_ready=0, no new capture; res_ready=1 -> IDLE next cycle.
- rst=1 in second CMP cycle -> next cycle IDLE, all flags 0, res_valid=0, start_ready=1; no result emitted.

Source files
------------

// File: rtl/seq_comparator_pkg.sv
// Shared types for the sequential comparator: FSM state encoding and
// one-hot result codes ordered {gt, eq, lt}.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/seq_comparator_if.sv
// Request/result handshake bundle for seq_comparator.
interface seq_comparator_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             res_valid;
    logic             res_ready;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             busy;

    modport master (
        output start_valid, a, b, signed_mode, res_ready,
        input  start_ready, res_valid, a_gt_b, a_eq_b, a_lt_b, busy
    );

    modport slave (
        input  start_valid, a, b, signed_mode, res_ready,
        output start_ready, res_valid, a_gt_b, a_eq_b, a_lt_b, busy
    );
endinterface

// File: rtl/seq_comparator_chunk.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
module cmp_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    assign gt = (x > y);
    assign eq = (x == y);
    assign lt = (x < y);
endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator, one CHUNK-bit slice per cycle, MSB first.
// Define SEQ_COMPARATOR_EARLY_EXIT_EN to finish on the first differing slice.
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic           clk,
    input logic           rst,
    seq_comparator_if.slave cif
);
    localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH - 1);

    if ((CHUNK < 1) || ((WIDTH % ((CHUNK == 0) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
        $fatal(1, "seq_comparator: CHUNK must be >= 1 and divide WIDTH");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IDXW-1:0]  idx_q;
    logic             decided_q;
    logic [2:0]       res_q;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic             c_gt, c_eq, c_lt;
    logic             last_chunk;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x  (a_sl),
        .y  (b_sl),
        .gt (c_gt),
        .eq (c_eq),
        .lt (c_lt)
    );

    assign last_chunk = (idx_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        cif.start_ready = 1'b0;
        cif.res_valid   = 1'b0;
        cif.busy        = 1'b0;
        unique case (state_q)
            IDLE: begin
                cif.start_ready = 1'b1;
                if (cif.start_valid) state_d = CMP;
            end
            CMP: begin
                cif.busy = 1'b1;
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
                if (last_chunk || !c_eq) state_d = DONE;
`else
                if (last_chunk) state_d = DONE;
`endif
            end
            DONE: begin
                cif.busy      = 1'b1;
                cif.res_valid = 1'b1;
                if (cif.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset forces the idle-looking outputs even before the edge lands.
        if (rst) begin
            cif.start_ready = 1'b1;
            cif.res_valid   = 1'b0;
            cif.busy        = 1'b0;
        end
    end

    // Signed compare becomes unsigned once both sign bits are inverted.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            res_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cif.start_valid) begin
                        a_q       <= cif.a ^ (cif.signed_mode ? MSB_MASK : '0);
                        b_q       <= cif.b ^ (cif.signed_mode ? MSB_MASK : '0);
                        idx_q     <= IDXW'(NCHUNK - 1);
                        decided_q <= 1'b0;
                        res_q     <= '0;
                    end
                end
                CMP: begin
                    if (!decided_q && !c_eq) begin
                        res_q     <= {c_gt, 1'b0, c_lt};
                        decided_q <= 1'b1;
                    end else if (last_chunk && !decided_q) begin
                        res_q <= EQ;
                    end
                    idx_q <= idx_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cif.a_gt_b = |(res_q & GT) & ~rst;
    assign cif.a_eq_b = |(res_q & EQ) & ~rst;
    assign cif.a_lt_b = |(res_q & LT) & ~rst;
endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator (WIDTH=16, CHUNK=4), either build.
module tb_seq_comparator;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [2:0]  flags;
        int          p;      // 1-based position of first differing nibble from MSB, 4 if equal
    } vec_t;

    typedef struct {
        logic [2:0] flags;
        int         lat;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    sb_t  sb_q[$];
    vec_t vecs[12];

    seq_comparator_if #(.WIDTH(16)) cif ();

    seq_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .cif (cif)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input int p);
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
        return p;
`else
        return 4;
`endif
    endfunction

    function automatic logic [2:0] flags_now();
        return {cif.a_gt_b, cif.a_eq_b, cif.a_lt_b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        sb_t e;
        sb_t got;
        int  cyc;
        e.flags = v.flags;
        e.lat   = lat_of(v.p);
        @(posedge clk); #1;
        chk("idle_start_ready", 32'(cif.start_ready), 1);
        cif.start_valid = 1'b1;
        cif.a           = v.a;
        cif.b           = v.b;
        cif.signed_mode = v.sm;
        sb_q.push_back(e);
        @(posedge clk); #1;
        cif.start_valid = 1'b0;
        cif.a           = '0;
        cif.b           = '0;
        cyc = 0;
        while (!cif.res_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        got = sb_q.pop_front();
        chk("latency", 32'(cyc), 32'(got.lat));
        chk("flags", 32'(flags_now()), 32'(got.flags));
        chk("onehot", 32'($countones(flags_now())), 1);
        chk("busy_done", 32'(cif.busy), 1);
        cif.res_ready = 1'b1;
        @(posedge clk); #1;
        cif.res_ready = 1'b0;
        chk("post_accept_ready", 32'(cif.start_ready), 1);
        chk("post_accept_valid", 32'(cif.res_valid), 0);
        chk("idle_flags_held", 32'(flags_now()), 32'(got.flags));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic seen;

        vecs[0]  = '{16'h1234, 16'h1234, 1'b0, F_EQ, 4};
        vecs[1]  = '{16'h8000, 16'h0001, 1'b0, F_GT, 1};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b1, F_LT, 1};
        vecs[3]  = '{16'hA000, 16'h5000, 1'b0, F_GT, 1};
        vecs[4]  = '{16'h0003, 16'h0004, 1'b0, F_LT, 4};
        vecs[5]  = '{16'hFFFF, 16'h0000, 1'b1, F_LT, 1};
        vecs[6]  = '{16'h7FFF, 16'h8000, 1'b1, F_GT, 1};
        vecs[7]  = '{16'h1235, 16'h1234, 1'b0, F_GT, 4};
        vecs[8]  = '{16'h12F4, 16'h1234, 1'b1, F_GT, 3};
        vecs[9]  = '{16'h0000, 16'h0000, 1'b1, F_EQ, 4};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, F_EQ, 4};
        vecs[11] = '{16'h1034, 16'h1234, 1'b0, F_LT, 2};

        cif.start_valid = 1'b0;
        cif.a           = '0;
        cif.b           = '0;
        cif.signed_mode = 1'b0;
        cif.res_ready   = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(cif.start_ready), 1);
        chk("rst_res_valid", 32'(cif.res_valid), 0);
        chk("rst_busy", 32'(cif.busy), 0);
        chk("rst_flags", 32'(flags_now()), 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // DONE stall with start_valid held high and a competing request.
        @(posedge clk); #1;
        cif.start_valid = 1'b1;
        cif.a           = 16'hA000;
        cif.b           = 16'h5000;
        cif.signed_mode = 1'b0;
        @(posedge clk); #1;
        cif.a = 16'h0000;
        cif.b = 16'hFFFF;
        cyc = 0;
        while (!cif.res_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_latency", 32'(cyc), 32'(lat_of(1)));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(cif.res_valid), 1);
            chk("stall_flags", 32'(flags_now()), 32'(F_GT));
            chk("stall_start_ready", 32'(cif.start_ready), 0);
        end
        cif.start_valid = 1'b0;
        cif.res_ready   = 1'b1;
        @(posedge clk); #1;
        cif.res_ready = 1'b0;
        chk("stall_exit_ready", 32'(cif.start_ready), 1);
        chk("stall_exit_busy", 32'(cif.busy), 0);
        chk("stall_no_capture", 32'(flags_now()), 32'(F_GT));

        // Reset in the second CMP cycle discards the operation.
        @(posedge clk); #1;
        cif.start_valid = 1'b1;
        cif.a           = 16'h0003;
        cif.b           = 16'h0004;
        @(posedge clk); #1;
        cif.start_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_cmp_busy", 32'(cif.busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", 32'(cif.start_ready), 1);
        chk("mid_rst_valid", 32'(cif.res_valid), 0);
        chk("mid_rst_busy", 32'(cif.busy), 0);
        chk("mid_rst_flags", 32'(flags_now()), 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            seen = seen | cif.res_valid;
        end
        chk("mid_rst_no_result", 32'(seen), 0);

        // Normal operation after the aborted request.
        run_vec(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
